// File: rtl/eyeriss_cfg_pkg.sv
// Configuration scan-chain layout shared by the loader and the chain itself.
// cfg_data packs fields MSB-first from H down to t; H sits at the scan_in end.
package eyeriss_cfg_pkg;

    localparam int H_WIDTH = 8;
    localparam int W_WIDTH = 8;
    localparam int R_WIDTH = 4;
    localparam int S_WIDTH = 4;
    localparam int E_WIDTH = 8;
    localparam int F_WIDTH = 8;
    localparam int C_WIDTH = 10;
    localparam int M_WIDTH = 10;
    localparam int N_WIDTH = 6;
    localparam int U_WIDTH = 3;
    localparam int m_WIDTH = 6;
    localparam int n_WIDTH = 4;
    localparam int e_WIDTH = 4;
    localparam int p_WIDTH = 3;
    localparam int q_WIDTH = 2;
    localparam int r_WIDTH = 2;
    localparam int t_WIDTH = 2;

    localparam int CHAIN_LEN = H_WIDTH + W_WIDTH + R_WIDTH + S_WIDTH + E_WIDTH
                             + F_WIDTH + C_WIDTH + M_WIDTH + N_WIDTH + U_WIDTH
                             + m_WIDTH + n_WIDTH + e_WIDTH + p_WIDTH + q_WIDTH
                             + r_WIDTH + t_WIDTH;

    // t is shifted in first, so it occupies the low end of cfg_data.
    localparam int t_LSB = 0;
    localparam int r_LSB = t_LSB + t_WIDTH;
    localparam int q_LSB = r_LSB + r_WIDTH;
    localparam int p_LSB = q_LSB + q_WIDTH;
    localparam int e_LSB = p_LSB + p_WIDTH;
    localparam int n_LSB = e_LSB + e_WIDTH;
    localparam int m_LSB = n_LSB + n_WIDTH;
    localparam int U_LSB = m_LSB + m_WIDTH;
    localparam int N_LSB = U_LSB + U_WIDTH;
    localparam int M_LSB = N_LSB + N_WIDTH;
    localparam int C_LSB = M_LSB + M_WIDTH;
    localparam int F_LSB = C_LSB + C_WIDTH;
    localparam int E_LSB = F_LSB + F_WIDTH;
    localparam int S_LSB = E_LSB + E_WIDTH;
    localparam int R_LSB = S_LSB + S_WIDTH;
    localparam int W_LSB = R_LSB + R_WIDTH;
    localparam int H_LSB = W_LSB + W_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } loader_state_t;

endpackage

// File: rtl/scan_chain_loader.sv
// Serialises one configuration word into the scan chain while capturing the
// previous chain contents as a parallel readback word.
module scan_chain_loader
    import eyeriss_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 cfg_loaded
);

    localparam int CNT_WIDTH = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CHAIN_LEN);

    loader_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   sreg_q, sreg_d;
    logic [CHAIN_LEN-1:0]   cap_q, cap_d;
    logic [CHAIN_LEN-1:0]   rd_data_q, rd_data_d;
    logic                   scan_en_q, scan_en_d;
    logic                   scan_in_q, scan_in_d;
    logic                   cfg_loaded_q, cfg_loaded_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            cap_q        <= '0;
            rd_data_q    <= '0;
            scan_en_q    <= 1'b0;
            scan_in_q    <= 1'b0;
            cfg_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            cap_q        <= cap_d;
            rd_data_q    <= rd_data_d;
            scan_en_q    <= scan_en_d;
            scan_in_q    <= scan_in_d;
            cfg_loaded_q <= cfg_loaded_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        cap_d        = cap_q;
        rd_data_d    = rd_data_q;
        scan_en_d    = scan_en_q;
        scan_in_d    = scan_in_q;
        cfg_loaded_d = cfg_loaded_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d   = SHIFT;
                    sreg_d    = cfg_data;
                    cnt_d     = '0;
                    scan_en_d = 1'b1;
                    scan_in_d = cfg_data[0];
                end
            end
            SHIFT: begin
                // scan_en is high throughout SHIFT, so every edge here shifts the chain.
                cap_d  = {scan_out, cap_q[CHAIN_LEN-1:1]};
                sreg_d = sreg_q >> 1;
                cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d      = DONE;
                    scan_en_d    = 1'b0;
                    scan_in_d    = 1'b0;
                    rd_data_d    = cap_d;
                    cfg_loaded_d = 1'b1;
                end else begin
                    scan_in_d = sreg_q[1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rd_valid   = (state_q == DONE);
    assign rd_data    = rd_data_q;
    assign scan_en    = scan_en_q;
    assign scan_in    = scan_in_q;
    assign cfg_loaded = cfg_loaded_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader driving a behavioural scan chain; the reference
// model tracks the word the chain should hold and the word each load returns.
module tb_scan_chain_loader;
    import eyeriss_cfg_pkg::*;

    localparam int LEN = CHAIN_LEN;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [LEN-1:0] cfg_data;
    logic           scan_en;
    logic           scan_in;
    logic           scan_out;
    logic [LEN-1:0] rd_data;
    logic           rd_valid;
    logic           busy;
    logic           cfg_loaded;

    logic [LEN-1:0] chain_q;     // index = position counted from the scan_in end
    logic [LEN-1:0] model_word;  // word the chain should hold, in cfg_data packing
    int             n_vec = 0;
    int             n_err = 0;
    int             n_load = 0;

    always #5 clk = ~clk;

    scan_chain_loader dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .cfg_loaded (cfg_loaded)
    );

    always @(posedge clk or posedge reset) begin
        if (reset)
            chain_q <= '0;
        else if (scan_en)
            chain_q <= {chain_q[LEN-2:0], scan_in};
    end
    assign scan_out = chain_q[LEN-1];

    function automatic logic [LEN-1:0] chain_word();
        logic [LEN-1:0] w;
        for (int i = 0; i < LEN; i++) w[i] = chain_q[LEN-1-i];
        return w;
    endfunction

    function automatic logic [LEN-1:0] set_field(input logic [LEN-1:0] w, input int lsb,
                                                 input int width, input logic [31:0] val);
        logic [LEN-1:0] r;
        r = w;
        for (int b = 0; b < width; b++) r[lsb+b] = val[b];
        return r;
    endfunction

    function automatic logic [31:0] get_field(input logic [LEN-1:0] w, input int lsb, input int width);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < width; b++) v[b] = w[lsb+b];
        return v;
    endfunction

    function automatic logic [LEN-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[LEN-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle where cfg_ready is back.
    task automatic do_load(input logic [LEN-1:0] w, input bit hold_next, input logic [LEN-1:0] next_w);
        int             waited = 0;
        int             en_cnt = 0, first_en = 0, last_en = 0;
        int             rv_cnt = 0, rv_cyc = 0, rdy_hi = 0, busy_cnt = 0;
        logic [LEN-1:0] stream = '0;
        logic [LEN-1:0] rd_seen = '0;
        logic [LEN-1:0] exp_rd;
        exp_rd    = model_word;
        cfg_valid = 1'b1;
        cfg_data  = w;
        while (!cfg_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!cfg_ready) begin
            check_eq("ready_timeout", 0, 1);
            cfg_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold_next) cfg_data = next_w;
        else cfg_valid = 1'b0;
        for (int c = 1; c <= LEN + 1; c++) begin
            if (scan_en) begin
                if (en_cnt == 0) first_en = c;
                if (en_cnt < LEN) stream[en_cnt] = scan_in;
                en_cnt++;
                last_en = c;
            end
            if (rd_valid) begin
                rv_cnt++;
                rv_cyc  = c;
                rd_seen = rd_data;
            end
            if (cfg_ready) rdy_hi++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        model_word = w;
        n_load++;
        check_eq("scan_en_cycles", en_cnt, LEN);
        check_eq("scan_en_first", first_en, 1);
        check_eq("scan_en_last", last_en, LEN);
        check_eq("scan_in_stream", stream, w);
        check_eq("rd_valid_pulses", rv_cnt, 1);
        check_eq("rd_valid_cycle", rv_cyc, LEN + 1);
        check_eq("rd_data", rd_seen, exp_rd);
        check_eq("ready_during_load", rdy_hi, 0);
        check_eq("busy_cycles", busy_cnt, LEN + 1);
        check_eq("chain_contents", chain_word(), w);
        check_eq("cfg_loaded", cfg_loaded, 1);
        check_eq("ready_after", cfg_ready, 1);
        $display("load %0d: wrote %h read back %h", n_load, w, rd_seen);
    endtask

    initial begin
        logic [LEN-1:0] w2, wa, wb, one;
        int             bad;

        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        model_word = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_cfg_ready", cfg_ready, 1);
        check_eq("rst_scan_en", scan_en, 0);
        check_eq("rst_scan_in", scan_in, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_cfg_loaded", cfg_loaded, 0);
        check_eq("rst_rd_data", rd_data, 0);
        reset = 1'b0;

        // Idle with no request.
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!cfg_ready || scan_en || busy || cfg_loaded || rd_valid) bad++;
        end
        check_eq("idle_quiet_cycles", bad, 0);
        $display("idle: 10 cycles, %0d bad", bad);

        // Layer-shape word with small fields set to 1.
        w2 = '0;
        w2 = set_field(w2, C_LSB, C_WIDTH, 1);
        w2 = set_field(w2, M_LSB, M_WIDTH, 1);
        w2 = set_field(w2, N_LSB, N_WIDTH, 1);
        w2 = set_field(w2, U_LSB, U_WIDTH, 1);
        w2 = set_field(w2, m_LSB, m_WIDTH, 1);
        w2 = set_field(w2, n_LSB, n_WIDTH, 1);
        w2 = set_field(w2, e_LSB, e_WIDTH, 1);
        w2 = set_field(w2, p_LSB, p_WIDTH, 1);
        w2 = set_field(w2, q_LSB, q_WIDTH, 1);
        w2 = set_field(w2, r_LSB, r_WIDTH, 1);
        w2 = set_field(w2, t_LSB, t_WIDTH, 1);
        w2 = set_field(w2, H_LSB, H_WIDTH, 32);
        w2 = set_field(w2, W_LSB, W_WIDTH, 32);
        w2 = set_field(w2, R_LSB, R_WIDTH, 3);
        w2 = set_field(w2, S_LSB, S_WIDTH, 3);
        w2 = set_field(w2, E_LSB, E_WIDTH, 30);
        w2 = set_field(w2, F_LSB, F_WIDTH, 30);
        do_load(w2, 1'b0, '0);
        check_eq("field_H", get_field(chain_word(), H_LSB, H_WIDTH), 32);
        check_eq("field_W", get_field(chain_word(), W_LSB, W_WIDTH), 32);
        check_eq("field_R", get_field(chain_word(), R_LSB, R_WIDTH), 3);
        check_eq("field_S", get_field(chain_word(), S_LSB, S_WIDTH), 3);
        check_eq("field_E", get_field(chain_word(), E_LSB, E_WIDTH), 30);
        check_eq("field_F", get_field(chain_word(), F_LSB, F_WIDTH), 30);
        check_eq("field_C", get_field(chain_word(), C_LSB, C_WIDTH), 1);
        check_eq("field_t", get_field(chain_word(), t_LSB, t_WIDTH), 1);

        // All-zero word returns the previous configuration.
        do_load('0, 1'b0, '0);

        // cfg_valid held through the shift with the next word.
        wa = rand_word();
        wb = rand_word();
        do_load(wa, 1'b1, wb);
        do_load(wb, 1'b0, '0);

        // Reset in shift cycle 40.
        cfg_valid = 1'b1;
        cfg_data  = rand_word();
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (39) @(negedge clk);
        check_eq("pre_abort_scan_en", scan_en, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_scan_en", scan_en, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_cfg_loaded", cfg_loaded, 0);
        check_eq("abort_chain", chain_word(), 0);
        model_word = '0;
        $display("abort: reset in shift cycle 40");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_load(rand_word(), 1'b0, '0);

        // Walking one through the ends and the middle.
        foreach (w2[i]) begin
            if (i == 0 || i == 45 || i == LEN - 1) begin
                one    = '0;
                one[i] = 1'b1;
                do_load(one, 1'b0, '0);
                check_eq("walk_chain_pos", chain_q[LEN-1-i], 1);
            end
        end
        do_load(rand_word(), 1'b0, '0);

        repeat (4) do_load(rand_word(), 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
